// File: rtl/pipe_muldiv_pkg.sv
// rtl/pipe_muldiv_pkg.sv - shared op and FSM state encodings for the multiply/divide unit
package pipe_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/pipe_muldiv_datapath.sv
// rtl/pipe_muldiv_datapath.sv - magnitude accumulator, shift-add/shift-subtract step and sign fixup
module muldiv_datapath
    import pipe_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sign_a = op_is_signed(op) & a[WIDTH-1];
        sign_b = op_is_signed(op) & b[WIDTH-1];
        abs_a  = sign_a ? -a : a;
        abs_b  = sign_b ? -b : b;
    end

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : {(WIDTH+1){1'b0}});
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        rem_ge   = rem_sh >= {1'b0, mag};
        rem_diff = rem_sh[WIDTH-1:0] - mag;
        if (is_div)
            acc_next = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};
        else
            acc_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Divide by zero leaves remainder = |a|, so only the quotient needs forcing.
    always_comb begin
        prod = neg_res ? -acc : acc;
        if (is_div) begin
            res_lo = div_zero ? {WIDTH{1'b1}}
                   : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            mag      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            is_div   <= op_is_div(op);
            mag      <= op_is_div(op) ? abs_b : abs_a;
            acc      <= {{WIDTH{1'b0}}, (op_is_div(op) ? abs_a : abs_b)};
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= (b == '0);
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/pipe_muldiv.sv
// rtl/pipe_muldiv.sv - iterative MULT/DIV unit with HI/LO registers, MTHI/MTLO and stall control
module pipe_muldiv
    import pipe_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             whi,
    input  logic             wlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    logic [CW-1:0]    count;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign load = (state == S_IDLE) && start && !flush;
    assign step = (state == S_RUN) && !flush;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .op     (op_e'(op)),
        .a      (a),
        .b      (b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // busy stays high through the ready cycle so the stall releases one cycle after results land.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (whi) hi <= wdata;
                        if (wlo) lo <= wdata;
                        if (start) begin
                            state <= S_RUN;
                            count <= '0;
                            busy  <= 1'b1;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        count <= count + CW'(1);
                        if (count == LAST) state <= S_DONE;
                    end
                    S_DONE: begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_muldiv.sv
// tb/tb_pipe_muldiv.sv - self-checking bench for pipe_muldiv
module tb_pipe_muldiv;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         flush = 1'b0;
    logic         whi   = 1'b0;
    logic         wlo   = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         ready;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int compared   = 0;
    int mismatched = 0;

    pipe_muldiv #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .whi   (whi),
        .wlo   (wlo),
        .wdata (wdata),
        .busy  (busy),
        .ready (ready),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic rules.
    function automatic logic [63:0] expect_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
        logic signed [31:0] sx, sy, q, r;
        logic [63:0]        up;
        sx = x;
        sy = y;
        case (o)
            2'b00: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                return up;
            end
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Cycle model: an accepted start produces its result WIDTH+1 edges later.
    int           m_left  = 0;
    logic         m_busy  = 1'b0;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_hi    = '0;
    logic [W-1:0] m_lo    = '0;
    logic [63:0]  m_res   = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_left  = 0;
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_hi    = '0;
            m_lo    = '0;
        end else begin
            m_ready = 1'b0;
            if (flush) begin
                m_left = 0;
                m_busy = 1'b0;
            end else if (m_left == 0) begin
                if (whi) m_hi = wdata;
                if (wlo) m_lo = wdata;
                if (start) begin
                    m_res  = expect_res(op, a, b);
                    m_left = W + 1;
                    m_busy = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_hi    = m_res[63:32];
                    m_lo    = m_res[31:0];
                    m_ready = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
        check("cyc_ready", {31'd0, ready}, {31'd0, m_ready});
        check("cyc_hi", hi, m_hi);
        check("cyc_lo", lo, m_lo);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one op while poking start/wlo mid-flight; both must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        int lat;
        lat = 0;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; a = ~x; b = y + 32'd3;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin start = 1'b1; op = ~o; end
            if (i == 6) start = 1'b0;
            if (i == 10) begin wlo = 1'b1; wdata = 32'hCAFE_F00D; end
            if (i == 11) wlo = 1'b0;
            tick();
            if (i == 10) check({nm, "_wlo_ignored"}, lo, m_lo);
            if (ready) begin lat = i; break; end
        end
        check({nm, "_latency"}, 32'(lat), 32'd33);
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
        tick();
        check({nm, "_busy_drop"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int saw;
        int lat;
        #1;
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;
        tick();

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, "multu");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
        run_op(2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_zero");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero");

        whi = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        whi = 1'b0;
        check("mthi", hi, 32'hDEAD_BEEF);
        whi = 1'b1; wlo = 1'b1; wdata = 32'h0000_AAAA;
        tick();
        whi = 1'b0; wdata = 32'h0000_5555;
        tick();
        wlo = 1'b0;
        check("mthi_pre", hi, 32'h0000_AAAA);
        check("mtlo_pre", lo, 32'h0000_5555);

        op = 2'b01; a = 32'h0001_2345; b = 32'h0000_0777; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_hi", hi, 32'h0000_AAAA);
        check("flush_lo", lo, 32'h0000_5555);
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready) saw = 1;
        end
        check("flush_no_ready", 32'(saw), 32'd0);
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", {31'd0, busy}, 32'd0);
        tick();
        check("start_flush_idle", {31'd0, busy}, 32'd0);

        whi = 1'b1; wdata = 32'h1111_1111; op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        whi = 1'b0; start = 1'b0;
        check("whi_start_hi", hi, 32'h1111_1111);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready) begin lat = i; break; end
        end
        check("whi_start_lat", 32'(lat), 32'd33);
        check("whi_start_res_hi", hi, 32'd0);
        check("whi_start_res_lo", lo, 32'd6);

        op = 2'b11; a = 32'd9; b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 32; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_done_ready", {31'd0, ready}, 32'd0);
        check("flush_done_busy", {31'd0, busy}, 32'd0);
        check("flush_done_hi", hi, 32'd0);
        check("flush_done_lo", lo, 32'd6);

        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, ready}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        run_op(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, "divu_after_rst");

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_muldiv.md
Name: pipe_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage of the pipelined CPU; sits directly upstream of the memory stage.
- Executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers. Holds busy high so the hazard unit stalls IF/ID/EX while an operation runs.
- Provides HI/LO values for MFHI/MFLO forwarding onto the EX result path, which becomes malu for the memory stage. Supports MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort in-flight operation (branch/exception squash).
- whi  in  1  MTHI write strobe.
- wlo  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  high while state != IDLE; drives pipeline stall.
- ready  out  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, hi=0, lo=0, busy=0, ready=0, internal counter and accumulators=0.
- FSM states:
  - IDLE: on start, latch |a|, |b|, operand signs and op; counter=0; go to RUN.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle. After WIDTH steps (counter==WIDTH-1), go to DONE.
  - DONE: apply sign fixup, write hi/lo, assert ready for this cycle only, return to IDLE.
- Latency: start sampled at edge 0; busy=1 from edge 0. Edges 1..WIDTH perform the iterations; DONE occupies edge WIDTH+1. ready=1 and the new hi/lo are visible after edge WIDTH+1 (33 cycles for WIDTH=32). busy=0 one cycle later.
- Signed ops (MULT, DIV) operate on magnitudes:
  - Product is negated if sign(a)^sign(b).
  - Quotient is negated if sign(a)^sign(b).
  - Remainder takes the sign of the dividend.
- Unsigned ops use a, b as-is.
- MUL result: hi=product[2W-1:W], lo=product[W-1:0].
- DIV result: lo=quotient, hi=remainder.
- Divide by zero: no trap. lo=all ones, hi=a, for both signed and unsigned. Same latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This result falls out of the magnitude algorithm and must not be special-cased differently.
- start while busy: ignored.
- flush: next state IDLE from any state, hi/lo unchanged, ready=0.
  - flush and start in the same cycle: flush wins, no operation starts.
  - flush during DONE: ready=0 and hi/lo are not written.
- whi/wlo: honoured only in IDLE; write wdata to hi/lo at the next edge. Ignored while busy; the hazard unit guarantees they do not occur then.
  - whi and start in the same IDLE cycle: whi takes effect, then the operation overwrites hi at completion.
- Operand capture: a/b changing after start have no effect.

Decomposition:
- Shared package: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and FSM state encodings (S_IDLE, S_RUN, S_DONE); both are reused by the control unit and hazard logic.
- One natural sub-module, muldiv_datapath: the 2W-bit accumulator, shift/add/subtract step, and sign fixup. The top module keeps the FSM, counter, HI/LO registers and MTHI/MTLO handling.

Test Plan:
- Reset mid-RUN (assert at cycle 10 of a DIVU) -> busy=0, ready=0, hi=lo=0 immediately, without waiting for a clock edge.
- MULT a=0xFFFFFFFD (-3), b=7 -> ready exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- Flush at cycle 20 of a MULTU with prior hi=0xAAAA, lo=0x5555 -> busy=0 next cycle, no ready pulse, hi/lo still 0xAAAA/0x5555. Then start and flush together -> stays IDLE.
- MTHI 0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle. wlo asserted while busy -> lo unchanged. start during RUN with different operands -> result reflects the original operands only.
